// File: rtl/adj_clock_period_meter_if.sv
// adj_clock_period_meter_if: tick/enable inputs and measurement outputs of the period meter
// Ports: clk_enable, tick_in (into the meter); measured_factor, measure_valid, locked, overflow (out of the meter)
interface adj_clock_period_meter_if #(
    parameter int INPUT_BIT_WIDTH = 8
);
    logic                       clk_enable;
    logic                       tick_in;
    logic [INPUT_BIT_WIDTH-1:0] measured_factor;
    logic                       measure_valid;
    logic                       locked;
    logic                       overflow;
    modport master (output clk_enable, tick_in, input measured_factor, measure_valid, locked, overflow);
    modport slave (input clk_enable, tick_in, output measured_factor, measure_valid, locked, overflow);
endinterface

// File: rtl/adj_clock_period_meter.sv
// adj_clock_period_meter: measures enabled cycles between tick strobes and reports the divider factor
// Ports: clk, rst_n (async active-low); bus.slave carries clk_enable/tick_in in and
// measured_factor/measure_valid/locked/overflow out
module adj_clock_period_meter #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int LOCK_COUNT      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    adj_clock_period_meter_if.slave       bus
);
    localparam int W = INPUT_BIT_WIDTH;
    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};
    localparam logic [3:0] LC = 4'(LOCK_COUNT);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
    state_t state, state_n;
    logic [W-1:0] cnt, cnt_n, mf, mf_n, m;
    logic [3:0] run, run_n;
    logic mv, mv_n, lk, lk_n, ov, ov_n;
    assign m = cnt + W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
            cnt   <= '0;
            run   <= '0;
            mf    <= '0;
            mv    <= 1'b0;
            lk    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            run   <= run_n;
            mf    <= mf_n;
            mv    <= mv_n;
            lk    <= lk_n;
            ov    <= ov_n;
        end
    end
    // run == 0 marks "no measurement since the last reference tick"
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        run_n   = run;
        mf_n    = mf;
        mv_n    = 1'b0;
        lk_n    = lk;
        ov_n    = ov;
        if (bus.clk_enable) begin
            if (state == SEARCH) begin
                if (bus.tick_in) begin
                    cnt_n   = '0;
                    state_n = TRACK;
                end
            end else if (bus.tick_in) begin
                mf_n    = m;
                mv_n    = 1'b1;
                ov_n    = 1'b0;
                cnt_n   = '0;
                run_n   = (run == 4'd0 || m != mf) ? 4'd1 : (run >= LC ? LC : run + 4'd1);
                lk_n    = run_n == LC;
                state_n = lk_n ? LOCKED : TRACK;
            end else if (cnt == CNT_LAST) begin
                ov_n    = 1'b1;
                lk_n    = 1'b0;
                run_n   = '0;
                state_n = SEARCH;
            end else begin
                cnt_n = cnt + W'(1);
            end
        end
    end
    assign bus.measured_factor = mf;
    assign bus.measure_valid   = mv;
    assign bus.locked          = lk;
    assign bus.overflow        = ov;
endmodule

// File: tb/tb_adj_clock_period_meter.sv
// tb_adj_clock_period_meter: table vectors, directed corner sequences and random tick trains vs a reference model
module tb_adj_clock_period_meter;
    localparam int W    = 8;
    localparam int LC   = 2;
    localparam int MAXF = (1 << W) - 1;
    logic clk;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    adj_clock_period_meter_if #(.INPUT_BIT_WIDTH(W)) bus ();
    adj_clock_period_meter #(.INPUT_BIT_WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Reference model: remembers whether a reference tick exists, how many enabled
    // non-tick cycles have elapsed, and the measurements taken since the reference.
    bit m_ref;
    int m_el;
    int hist[$];
    int e_mf;
    bit e_mv, e_lk, e_ov;
    task automatic model_reset();
        m_ref = 0;
        m_el  = 0;
        hist.delete();
        e_mf = 0;
        e_mv = 0;
        e_lk = 0;
        e_ov = 0;
    endtask
    task automatic model(input bit en, input bit tk);
        e_mv = 0;
        if (!en) return;
        if (!m_ref) begin
            if (tk) begin
                m_ref = 1;
                m_el  = 0;
                hist.delete();
            end
        end else if (tk) begin
            e_mf = m_el + 1;
            e_mv = 1;
            e_ov = 0;
            m_el = 0;
            hist.push_back(e_mf);
            if (hist.size() > LC) void'(hist.pop_front());
            e_lk = hist.size() == LC;
            foreach (hist[i]) if (hist[i] != e_mf) e_lk = 0;
        end else begin
            m_el++;
            if (m_el + 1 > MAXF) begin
                m_ref = 0;
                e_ov  = 1;
                e_lk  = 0;
                hist.delete();
            end
        end
    endtask
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input bit en, input bit tk);
        bus.clk_enable = en;
        bus.tick_in    = tk;
        @(posedge clk);
        model(en, tk);
        #1;
        chk("factor", int'(bus.measured_factor), e_mf);
        chk("valid", int'(bus.measure_valid), int'(e_mv));
        chk("locked", int'(bus.locked), int'(e_lk));
        chk("overflow", int'(bus.overflow), int'(e_ov));
    endtask
    task automatic outs_zero(input string tag);
        chk({tag, "_factor"}, int'(bus.measured_factor), 0);
        chk({tag, "_valid"}, int'(bus.measure_valid), 0);
        chk({tag, "_locked"}, int'(bus.locked), 0);
        chk({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask
    task automatic do_reset();
        bus.clk_enable = 0;
        bus.tick_in    = 0;
        rst_n = 0;
        model_reset();
        #1;
        outs_zero("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask
    task automatic train(input int p, input int reps);
        for (int r = 0; r < reps; r++)
            for (int c = 0; c < p; c++) step(1, c == p - 1);
    endtask
    typedef struct packed {
        logic       en;
        logic       tick;
        logic       mv;
        logic [7:0] mf;
        logic       lk;
        logic       ov;
    } vec_t;
    vec_t tbl[19];
    initial begin
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0}
        };
        rst_n = 0;
        bus.clk_enable = 0;
        bus.tick_in    = 0;
        model_reset();
        @(posedge clk);
        #1;
        outs_zero("reset");
        rst_n = 1;
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].tick);
            chk("tbl_valid", int'(bus.measure_valid), int'(tbl[i].mv));
            chk("tbl_factor", int'(bus.measured_factor), int'(tbl[i].mf));
            chk("tbl_locked", int'(bus.locked), int'(tbl[i].lk));
            chk("tbl_overflow", int'(bus.overflow), int'(tbl[i].ov));
        end
        // factor change while locked
        train(5, 3);
        chk("chg_locked5", int'(bus.locked), 1);
        train(7, 1);
        chk("chg_factor7", int'(bus.measured_factor), 7);
        chk("chg_unlock", int'(bus.locked), 0);
        train(7, 1);
        chk("chg_relock", int'(bus.locked), 1);
        // enable gating: ticks every 4th enabled cycle, disabled cycles in between
        for (int k = 0; k < 24; k++) begin
            step(1, k % 4 == 3);
            step(0, 1'($urandom % 2));
        end
        chk("gate_factor", int'(bus.measured_factor), 4);
        chk("gate_locked", int'(bus.locked), 1);
        // overflow after 255 enabled cycles without a tick
        train(5, 2);
        for (int k = 0; k < 254; k++) step(1, 0);
        chk("pre_ovf", int'(bus.overflow), 0);
        step(1, 0);
        chk("ovf_flag", int'(bus.overflow), 1);
        chk("ovf_unlock", int'(bus.locked), 0);
        chk("ovf_held", int'(bus.measured_factor), 5);
        step(1, 1);
        chk("ovf_ref_novalid", int'(bus.measure_valid), 0);
        train(3, 1);
        chk("ovf_meas_valid", int'(bus.measure_valid), 1);
        chk("ovf_meas3", int'(bus.measured_factor), 3);
        chk("ovf_clear", int'(bus.overflow), 0);
        // range edges
        train(254, 1);
        chk("edge_254", int'(bus.measured_factor), 254);
        step(1, 1);
        chk("edge_1a", int'(bus.measured_factor), 1);
        step(1, 1);
        chk("edge_1b_valid", int'(bus.measure_valid), 1);
        chk("edge_1b_locked", int'(bus.locked), 1);
        // async reset at count 3
        train(4, 2);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        do_reset();
        step(1, 1);
        chk("post_rst_ref", int'(bus.measure_valid), 0);
        train(6, 2);
        chk("post_rst_lock", int'(bus.locked), 1);
        // random tick trains with random disabled gaps
        for (int b = 0; b < 60; b++) begin
            int p, reps;
            p    = ($urandom % 10 == 0) ? int'($urandom_range(250, 258)) : int'($urandom_range(1, 12));
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++)
                for (int c = 0; c < p; c++) begin
                    while ($urandom % 4 == 0) step(0, 1'($urandom % 2));
                    step(1, c == p - 1);
                end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adj_clock_period_meter.md
# adj_clock_period_meter

Measures the interval between consecutive tick strobes in enabled clock cycles and reports it as a divider factor. It performs the inverse of the adjustable clock divider: given that divider's one-cycle enable output, it recovers the programmed factor and flags when the recovered value is stable. It sits on the receive side of rate-recovery paths and feeds factor-tracking logic and status registers.

## Interface
- INPUT_BIT_WIDTH, 8: width of the measurement counter and of MeasuredFactor; measurable range is 1 to 2^INPUT_BIT_WIDTH-1.
- LOCK_COUNT, 2: number of consecutive identical measurements needed to assert Locked; legal range is 1 to 15.
- Clk  in  1  clock; all state changes on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- ClkEnable  in  1  qualifies every cycle; when low, all state is frozen.
- TickIn  in  1  one-cycle tick strobe; sampled only when ClkEnable=1.
- MeasuredFactor  out  INPUT_BIT_WIDTH  last valid measured interval; held between updates.
- MeasureValid  out  1  one-cycle pulse when MeasuredFactor updates.
- Locked  out  1  high while the last LOCK_COUNT measurements are identical.
- Overflow  out  1  sticky; the interval exceeded the range; cleared by the next MeasureValid.

## Operation
- **Enabled cycle:** any cycle with ClkEnable=1. A tick is an enabled cycle with TickIn=1.
- **Internal state:**
  - Cnt: INPUT_BIT_WIDTH bits.
  - Run: run-length counter, saturating at LOCK_COUNT.
  - FSM states: SEARCH, TRACK, LOCKED.
- **SEARCH** (reset state; no reference tick yet):
  - On a tick: Cnt<=0, go to TRACK. No measurement is made.
  - Non-tick enabled cycles: no change.
- **TRACK / LOCKED, non-tick enabled cycle:**
  - If Cnt < 2^W-2: Cnt<=Cnt+1.
  - If Cnt == 2^W-2 (interval would exceed 2^W-1): timeout. Overflow<=1, Locked<=0, Run<=0, go to SEARCH. MeasuredFactor is held.
- **TRACK / LOCKED, tick:**
  - M = Cnt+1, computed at width W; it never wraps because of the timeout rule.
  - MeasuredFactor<=M, MeasureValid<=1, Overflow<=0, Cnt<=0.
  - Run update: Run<=1 if this is the first measurement since SEARCH or M != previous MeasuredFactor; otherwise Run<=min(Run+1, LOCK_COUNT).
  - If the new Run == LOCK_COUNT: Locked<=1 and go to LOCKED. Otherwise Locked<=0 and go to TRACK.
  - In LOCKED, a mismatching M sets Run=1, so Locked drops in the same update, unless LOCK_COUNT=1.
- **Reference behaviour:** ticks every F enabled cycles yield M=F exactly. Disabled cycles between ticks are not counted.
- **ClkEnable=0:** Cnt, FSM, Run and outputs hold, except MeasureValid, which returns to 0.

## Timing
- **Reset** (asynchronous assert; deassert is synchronous to Clk, handled by the reset bridge upstream):
  - MeasuredFactor=0, MeasureValid=0, Locked=0, Overflow=0.
  - Cnt=0, Run=0, FSM=SEARCH.
- **Reset mid-measurement:** the partial count is discarded. The next tick after release is a reference tick, not a measurement.
- **Latency:** MeasureValid, MeasuredFactor, Locked and Overflow-clear are all registered and visible the cycle after the tick cycle.
- **Timeout:** Overflow rises the cycle after the offending non-tick enabled cycle, which is the (2^W-1)th enabled cycle after the last tick.
- **Minimum interval:** ticks on two consecutive enabled cycles measure 1. Back-to-back ticks produce a MeasureValid pulse on consecutive cycles.
- **Tick during timeout:** impossible. The tick branch has priority because a tick always resolves the interval.
- **No handshake:** MeasureValid is a pulse with no backpressure. Consumers must capture it in the same cycle.

## Test plan
- **Basic measurement** (W=8, LOCK_COUNT=2): ticks every 5 cycles with ClkEnable=1 -> no pulse on the first tick; MeasureValid pulses with 5 on the 2nd tick; Locked=1 after the 3rd tick; Locked stays high.
- **Factor change while locked:** 5,5,5 then one interval of 7 -> MeasuredFactor=7 and Locked=0 in the same update. A further 7 -> Locked=1.
- **ClkEnable gating:** ClkEnable toggles 1/0 every cycle, with ticks on every 4th enabled cycle -> measures 4, not 8. Outputs are unchanged during disabled cycles.
- **Overflow:** W=8, no tick for 255 enabled cycles after the reference tick -> Overflow=1, Locked=0, MeasuredFactor held. The next tick is a reference only. The following tick at interval 3 -> MeasureValid with 3 and Overflow=0.
- **Range edges:** ticks at interval 254 -> measures 254. Ticks on consecutive enabled cycles -> measures 1 on every cycle, and Locked asserts on the 3rd tick.
- **Async reset mid-count:** nReset low for 1.5 cycles at Cnt=3 -> all outputs 0 immediately. After release, the first tick produces no MeasureValid.
